// File: rtl/handshake_rx_pkg.sv
// Shared types and elaboration-time helpers for the four-phase frame receiver.
package handshake_rx_pkg;

  typedef enum logic {IDLE = 1'b0, ACKED = 1'b1} rx_state_t;

  localparam int DEF_DATA_W      = 6;
  localparam int DEF_CHUNK_W     = 6;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_FIFO_DEPTH  = 2;

  function automatic int f_ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

  function automatic int f_clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // Chunk index width; a single-chunk frame still needs a 1-bit port.
  function automatic int f_idx_w(input int data_w, input int chunk_w);
    int n;
    n = f_ceil_div(data_w, chunk_w);
    return (n > 1) ? f_clog2(n) : 1;
  endfunction

endpackage

// File: rtl/handshake_frame_fifo.sv
// Small synchronous frame FIFO; head is read straight from storage.
module handshake_frame_fifo
  import handshake_rx_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              push,
  input  logic [DATA_W-1:0]                 push_data,
  input  logic                              pop,
  output logic [DATA_W-1:0]                 head,
  output logic [f_clog2(FIFO_DEPTH):0]      count,
  output logic                              full,
  output logic                              empty
);

  localparam int PTR_W = f_clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic              do_push, do_pop;

  assign full    = (count == CNT_W'(FIFO_DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Power-of-two depth lets the pointers wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/handshake_frame_receiver.sv
// Four-phase chunk receiver: synchronises req, assembles chunks LSB-first and
// queues finished frames; backpressure is applied by withholding ack.
module handshake_frame_receiver
  import handshake_rx_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int CHUNK_W     = DEF_CHUNK_W,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH
) (
  input  logic                                  clk_receiver,
  input  logic                                  rst,
  input  logic                                  wire_req,
  input  logic [CHUNK_W-1:0]                    wire_data_deliver,
  output logic                                  reg_ack,
  output logic [DATA_W-1:0]                     data_out,
  output logic                                  data_valid,
  input  logic                                  data_ready,
  output logic [f_idx_w(DATA_W, CHUNK_W)-1:0]   chunk_idx,
  output logic [15:0]                           frame_count,
  output logic                                  stall
);

  localparam int NCHUNK = f_ceil_div(DATA_W, CHUNK_W);
  localparam int IDX_W  = f_idx_w(DATA_W, CHUNK_W);
  localparam int CNT_W  = f_clog2(FIFO_DEPTH) + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   req_s;
  rx_state_t              state_q, state_d;
  logic                   accept, refuse, finish, is_last, push;
  logic [DATA_W-1:0]      asm_q;
  logic [CNT_W-1:0]       fifo_count;
  logic                   fifo_full, fifo_empty;

  always_ff @(posedge clk_receiver or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], wire_req};
  end
  assign req_s = sync_q[SYNC_STAGES-1];

  assign is_last = (chunk_idx == LAST_IDX);
  assign push    = finish && is_last;

  // Space check uses the registered count only, so a same-cycle pop is not
  // credited until the following cycle.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    refuse  = 1'b0;
    finish  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_s) begin
          if (!is_last || !fifo_full) begin
            accept  = 1'b1;
            state_d = ACKED;
          end else begin
            refuse = 1'b1;
          end
        end
      end
      ACKED: begin
        if (!req_s) begin
          finish  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_receiver or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      reg_ack     <= 1'b0;
      stall       <= 1'b0;
      chunk_idx   <= '0;
      frame_count <= '0;
    end else begin
      state_q <= state_d;
      stall   <= refuse;
      if (accept)      reg_ack <= 1'b1;
      else if (finish) reg_ack <= 1'b0;
      if (finish) chunk_idx <= is_last ? '0 : chunk_idx + 1'b1;
      if (push)   frame_count <= frame_count + 16'd1;
    end
  end

  // Per-bit assembly: bits beyond DATA_W in the last chunk have no flop at all.
  for (genvar gi = 0; gi < DATA_W; gi++) begin : g_asm
    always_ff @(posedge clk_receiver or posedge rst) begin
      if (rst)
        asm_q[gi] <= 1'b0;
      else if (accept && chunk_idx == IDX_W'(gi / CHUNK_W))
        asm_q[gi] <= wire_data_deliver[gi % CHUNK_W];
    end
  end

  handshake_frame_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk_receiver),
    .rst       (rst),
    .push      (push),
    .push_data (asm_q),
    .pop       (data_ready),
    .head      (data_out),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign data_valid = !fifo_empty;

endmodule

// File: tb/tb_handshake_frame_receiver.sv
// Directed + randomized bench: a 16-bit/6-bit-chunk receiver checked against a
// frame queue model, plus a single-chunk instance for the basic latency case.
module tb_handshake_frame_receiver;

  logic        clk = 1'b0;
  logic        rst;
  logic        wire_req, reg_ack, data_valid, data_ready, stall;
  logic [5:0]  wire_data;
  logic [15:0] data_out, frame_count;
  logic [1:0]  chunk_idx;

  logic        req1, ack1, valid1, stall1;
  logic [5:0]  data1, out1;
  logic [0:0]  idx1;
  logic [15:0] fc1;
  logic        ready1 = 1'b0;

  int          n_assert = 0;
  int          n_fail   = 0;
  bit          rnd_ready;
  logic [15:0] model_q[$];
  logic [15:0] model_fc;

  always #5 clk = ~clk;

  handshake_frame_receiver #(.DATA_W(16), .CHUNK_W(6), .SYNC_STAGES(2), .FIFO_DEPTH(2)) dut (
    .clk_receiver(clk), .rst(rst), .wire_req(wire_req), .wire_data_deliver(wire_data),
    .reg_ack(reg_ack), .data_out(data_out), .data_valid(data_valid), .data_ready(data_ready),
    .chunk_idx(chunk_idx), .frame_count(frame_count), .stall(stall));

  handshake_frame_receiver #(.DATA_W(6), .CHUNK_W(6), .SYNC_STAGES(2), .FIFO_DEPTH(2)) dut1 (
    .clk_receiver(clk), .rst(rst), .wire_req(req1), .wire_data_deliver(data1),
    .reg_ack(ack1), .data_out(out1), .data_valid(valid1), .data_ready(ready1),
    .chunk_idx(idx1), .frame_count(fc1), .stall(stall1));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_ready) data_ready = 1'($urandom_range(0, 1));
  endtask

  // Every pop the DUT will perform on the next edge must match the oldest frame sent.
  always @(negedge clk) begin
    if (!rst && data_valid && data_ready) begin
      if (model_q.size() == 0) check("pop_unexpected", 32'(data_out), 32'hFFFF_FFFF);
      else                     check("pop_data", 32'(data_out), 32'(model_q.pop_front()));
    end
  end

  task automatic req_phase(input logic [5:0] c);
    bit ok;
    ok = 1'b0;
    wire_data = c;
    wire_req  = 1'b1;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (reg_ack) begin ok = 1'b1; break; end
    end
    check("ack_rise", 32'(ok), 32'd1);
  endtask

  task automatic rel_phase();
    bit ok;
    ok = 1'b0;
    wire_req = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (!reg_ack) begin ok = 1'b1; break; end
    end
    check("ack_fall", 32'(ok), 32'd1);
  endtask

  task automatic send_chunk(input logic [5:0] c);
    req_phase(c);
    rel_phase();
  endtask

  // Frame = three chunks LSB first; bits 16..17 of the raw stream are dropped.
  task automatic send_frame(input logic [17:0] raw);
    for (int i = 0; i < 3; i++) send_chunk(raw[i*6 +: 6]);
    model_q.push_back(raw[15:0]);
    model_fc++;
  endtask

  task automatic drain();
    rnd_ready  = 1'b0;
    data_ready = 1'b1;
    for (int i = 0; i < 50 && model_q.size() > 0; i++) tick();
    data_ready = 1'b0;
    check("drain_empty", 32'(model_q.size()), 32'd0);
    check("drain_valid", 32'(data_valid), 32'd0);
  endtask

  initial begin
    logic [17:0] raw, a, b;
    rst = 1'b1; wire_req = 1'b0; wire_data = '0; data_ready = 1'b0;
    req1 = 1'b0; data1 = '0; rnd_ready = 1'b0; model_fc = '0;
    repeat (3) tick();
    check("rst_ack", 32'(reg_ack), 32'd0);
    check("rst_valid", 32'(data_valid), 32'd0);
    check("rst_data", 32'(data_out), 32'd0);
    check("rst_idx", 32'(chunk_idx), 32'd0);
    check("rst_fc", 32'(frame_count), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    rst = 1'b0;
    tick();

    // single-chunk instance: ack appears on the third edge after req
    data1 = 6'h2A; req1 = 1'b1;
    tick(); check("t1_ack_e1", 32'(ack1), 32'd0);
    tick(); check("t1_ack_e2", 32'(ack1), 32'd0);
    tick(); check("t1_ack_e3", 32'(ack1), 32'd1);
    req1 = 1'b0;
    for (int i = 0; i < 10 && ack1; i++) tick();
    check("t1_ack_fall", 32'(ack1), 32'd0);
    check("t1_data", 32'(out1), 32'h2A);
    check("t1_valid", 32'(valid1), 32'd1);
    check("t1_fc", 32'(fc1), 32'd1);

    // multi-chunk assembly with dropped top bits
    raw = {6'h3B, 6'h3F, 6'h01};
    check("t2_idx0", 32'(chunk_idx), 32'd0);
    for (int i = 0; i < 3; i++) begin
      send_chunk(raw[i*6 +: 6]);
      check("t2_idx", 32'(chunk_idx), 32'((i + 1) % 3));
    end
    model_q.push_back(raw[15:0]);
    model_fc++;
    check("t2_data", 32'(data_out), 32'(raw[15:0]));
    check("t2_valid", 32'(data_valid), 32'd1);
    check("t2_fc", 32'(frame_count), 32'(model_fc));
    drain();

    // backpressure: third frame's last chunk refused until a slot frees
    send_frame(18'($urandom));
    send_frame(18'($urandom));
    raw = 18'($urandom);
    send_chunk(raw[5:0]);
    send_chunk(raw[11:6]);
    wire_data = raw[17:12]; wire_req = 1'b1;
    repeat (10) tick();
    check("t3_no_ack", 32'(reg_ack), 32'd0);
    check("t3_stall", 32'(stall), 32'd1);
    data_ready = 1'b1;
    tick();
    data_ready = 1'b0;
    req_phase(raw[17:12]);
    check("t3_stall_clr", 32'(stall), 32'd0);
    rel_phase();
    model_q.push_back(raw[15:0]);
    model_fc++;
    check("t3_fc", 32'(frame_count), 32'(model_fc));
    drain();

    // held req is taken once; index moves only after req drops
    raw = 18'($urandom);
    wire_data = raw[5:0]; wire_req = 1'b1;
    repeat (20) tick();
    check("t4_ack_held", 32'(reg_ack), 32'd1);
    check("t4_idx_held", 32'(chunk_idx), 32'd0);
    rel_phase();
    check("t4_idx_adv", 32'(chunk_idx), 32'd1);
    send_chunk(raw[11:6]);
    send_chunk(raw[17:12]);
    model_q.push_back(raw[15:0]);
    model_fc++;
    check("t4_fc", 32'(frame_count), 32'(model_fc));
    drain();

    // reset mid-frame discards the partial frame
    send_chunk(6'($urandom));
    check("t5_idx_mid", 32'(chunk_idx), 32'd1);
    rst = 1'b1;
    #1;
    check("t5_idx_async", 32'(chunk_idx), 32'd0);
    tick();
    rst = 1'b0;
    model_q.delete();
    model_fc = '0;
    tick();
    raw = 18'($urandom);
    send_frame(raw);
    check("t5_data", 32'(data_out), 32'(raw[15:0]));
    check("t5_valid", 32'(data_valid), 32'd1);
    check("t5_fc", 32'(frame_count), 32'd1);
    drain();

    // push and pop land on the same edge with one frame already queued
    a = 18'($urandom);
    b = 18'($urandom);
    send_frame(a);
    send_chunk(b[5:0]);
    send_chunk(b[11:6]);
    req_phase(b[17:12]);
    wire_req = 1'b0;
    tick();
    tick();
    data_ready = 1'b1;
    tick();
    data_ready = 1'b0;
    model_q.push_back(b[15:0]);
    model_fc++;
    check("t6_ack_fall", 32'(reg_ack), 32'd0);
    check("t6_head", 32'(data_out), 32'(b[15:0]));
    check("t6_valid", 32'(data_valid), 32'd1);
    check("t6_fc", 32'(frame_count), 32'(model_fc));
    send_frame(18'($urandom));
    check("t6_fc2", 32'(frame_count), 32'(model_fc));
    drain();

    // random consumer back-pressure against the queue model
    rnd_ready = 1'b1;
    for (int f = 0; f < 20; f++) send_frame(18'($urandom));
    drain();
    check("final_fc", 32'(frame_count), 32'(model_fc));
    check("final_idx", 32'(chunk_idx), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
